// File: rtl/pipelined_alu.sv
// -----------------------------------------------------------------------------
// pipelined_alu
//   Two-stage valid/ready ALU with an internal accumulator.
//   Stage 1 (S1) registers the request (a, b, op). Stage 2 (S2) registers the
//   computed result, its flags and out_valid. The accumulator is updated only
//   when an op moves from S1 to S2, so consecutive ACC ops see each other's
//   result without any hazard gap.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : synchronous active-high reset
//   in_valid   : request present on a/b/op
//   in_ready   : request accepted this cycle (combinational from state, out_ready, rst)
//   a, b       : unsigned operands, WIDTH bits
//   op         : opcode (AND, ADD, OR, SUB, XOR, ACC_ADD, ACC_CLR, PASS_A)
//   out_valid  : r/neg/zero hold a valid result
//   out_ready  : consumer accepts the result this cycle
//   r          : result, WIDTH+1 bits
//   neg, zero  : result flags
// -----------------------------------------------------------------------------
module pipelined_alu #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   r,
    output logic             neg,
    output logic             zero
);

    localparam logic [2:0] OP_AND     = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_OR      = 3'b010;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_XOR     = 3'b100;
    localparam logic [2:0] OP_ACC_ADD = 3'b101;
    localparam logic [2:0] OP_ACC_CLR = 3'b110;
    localparam logic [2:0] OP_PASS_A  = 3'b111;

    // Stage 1 request registers
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [2:0]       r_s1_op;

    // Stage 2 result registers and accumulator
    logic             r_out_valid;
    logic [WIDTH:0]   r_res;
    logic             r_neg;
    logic             r_zero;
    logic [WIDTH:0]   r_acc;

    // Handshake and datapath wires
    logic             w_s2_free;
    logic             w_s1_adv;
    logic             w_in_ready;
    logic             w_in_xfer;
    logic [WIDTH:0]   w_ext_a;
    logic [WIDTH:0]   w_ext_b;
    logic [WIDTH:0]   w_res;
    logic             w_neg;
    logic             w_zero;
    logic [WIDTH:0]   w_acc_next;

    // S2 can take a new result when empty or when its current result leaves now.
    assign w_s2_free  = !r_out_valid || out_ready;
    assign w_s1_adv   = r_s1_valid && w_s2_free;
    // rst forces in_ready low so a request coincident with reset is never taken.
    assign w_in_ready = !rst && (!r_s1_valid || w_s1_adv);
    assign w_in_xfer  = in_valid && w_in_ready;

    assign w_ext_a = {1'b0, r_s1_a};
    assign w_ext_b = {1'b0, r_s1_b};

    // Result, flags and next accumulator value for the op sitting in S1.
    always_comb begin
        w_res      = {(WIDTH+1){1'b0}};
        w_neg      = 1'b0;
        w_acc_next = r_acc;
        case (r_s1_op)
            OP_AND:     w_res = w_ext_a & w_ext_b;
            OP_ADD:     w_res = w_ext_a + w_ext_b;
            OP_OR:      w_res = w_ext_a | w_ext_b;
            OP_SUB: begin
                // WIDTH+1-bit subtraction wraps modulo 2^(WIDTH+1)
                w_res = w_ext_a - w_ext_b;
                w_neg = (r_s1_b > r_s1_a);
            end
            OP_XOR:     w_res = w_ext_a ^ w_ext_b;
            OP_ACC_ADD: begin
                w_res      = r_acc + w_ext_a;
                w_acc_next = r_acc + w_ext_a;
            end
            OP_ACC_CLR: begin
                w_res      = r_acc;
                w_acc_next = {(WIDTH+1){1'b0}};
            end
            OP_PASS_A:  w_res = w_ext_a;
            default:    w_res = {(WIDTH+1){1'b0}};
        endcase
        w_zero = (w_res == {(WIDTH+1){1'b0}});
    end

    // Stage 1: capture a request on input transfer, empty when it moves to S2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= {WIDTH{1'b0}};
            r_s1_b     <= {WIDTH{1'b0}};
            r_s1_op    <= 3'b000;
        end else if (w_in_xfer) begin
            r_s1_valid <= 1'b1;
            r_s1_a     <= a;
            r_s1_b     <= b;
            r_s1_op    <= op;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= r_s1_valid;
        end
    end

    // Stage 2: load result and commit the accumulator when S1 advances; hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_res       <= {(WIDTH+1){1'b0}};
            r_neg       <= 1'b0;
            r_zero      <= 1'b0;
            r_acc       <= {(WIDTH+1){1'b0}};
        end else if (w_s1_adv) begin
            r_out_valid <= 1'b1;
            r_res       <= w_res;
            r_neg       <= w_neg;
            r_zero      <= w_zero;
            r_acc       <= w_acc_next;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign r         = r_res;
    assign neg       = r_neg;
    assign zero      = r_zero;

endmodule

// File: tb/tb_pipelined_alu.sv
// -----------------------------------------------------------------------------
// tb_pipelined_alu
//   Drives a WIDTH=4 and a WIDTH=16 instance with the same control traffic.
//   Each accepted request is turned into an expected result by a plain
//   arithmetic model and queued; every output transfer pops and compares.
//   Directed tables and sequences cover the hand-computed corner cases.
// -----------------------------------------------------------------------------
module tb_pipelined_alu;

    localparam logic [2:0] OP_AND     = 3'd0;
    localparam logic [2:0] OP_ADD     = 3'd1;
    localparam logic [2:0] OP_OR      = 3'd2;
    localparam logic [2:0] OP_SUB     = 3'd3;
    localparam logic [2:0] OP_XOR     = 3'd4;
    localparam logic [2:0] OP_ACC_ADD = 3'd5;
    localparam logic [2:0] OP_ACC_CLR = 3'd6;
    localparam logic [2:0] OP_PASS_A  = 3'd7;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [2:0]  op;
    logic [15:0] a16;
    logic [15:0] b16;

    logic        rdy4, ov4, neg4, zero4;
    logic [4:0]  r4;
    logic        rdy16, ov16, neg16, zero16;
    logic [16:0] r16;

    pipelined_alu #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
        .a(a16[3:0]), .b(b16[3:0]), .op(op),
        .out_valid(ov4), .out_ready(out_ready),
        .r(r4), .neg(neg4), .zero(zero4)
    );

    pipelined_alu #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16),
        .a(a16), .b(b16), .op(op),
        .out_valid(ov16), .out_ready(out_ready),
        .r(r16), .neg(neg16), .zero(zero16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [32:0] r;
        logic        n;
        logic        z;
    } exp_t;

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] r;
        logic       n;
        logic       z;
    } vec_t;

    exp_t        q4[$];
    exp_t        q16[$];
    logic [32:0] acc4;
    logic [32:0] acc16;
    int          n_checks;
    int          n_fail;

    // stall-stability tracking
    logic        hold4;
    logic [4:0]  prev_r4;
    logic        prev_n4, prev_z4;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: straight arithmetic on wide integers, masked to WIDTH+1 bits.
    function automatic exp_t model(input int w, input logic [2:0] o,
                                   input logic [31:0] av, input logic [31:0] bv,
                                   inout logic [32:0] acc);
        exp_t   e;
        longint m;
        longint ua;
        longint ub;
        longint v;
        m  = (64'sd1 <<< (w + 1)) - 64'sd1;
        ua = longint'(av);
        ub = longint'(bv);
        case (o)
            OP_AND:     v = ua & ub;
            OP_ADD:     v = ua + ub;
            OP_OR:      v = ua | ub;
            OP_SUB:     v = ua - ub;
            OP_XOR:     v = ua ^ ub;
            OP_ACC_ADD: begin v = longint'(acc) + ua; acc = 33'(v & m); end
            OP_ACC_CLR: begin v = longint'(acc); acc = 33'd0; end
            default:    v = ua;
        endcase
        v   = v & m;
        e.r = 33'(v);
        e.n = (o == OP_SUB) && (ub > ua);
        e.z = (v == 64'sd0);
        return e;
    endfunction

    // Per-cycle scoreboard, evaluated mid-cycle where the handshakes are settled.
    task automatic monitor();
        exp_t e;
        if (rst) begin
            q4.delete();
            q16.delete();
            acc4  = 33'd0;
            acc16 = 33'd0;
            hold4 = 1'b0;
        end else begin
            if (hold4) begin
                check("stall_valid4", {32'd0, ov4}, 33'd1);
                check("stall_r4", {28'd0, r4}, {28'd0, prev_r4});
                check("stall_neg4", {32'd0, neg4}, {32'd0, prev_n4});
                check("stall_zero4", {32'd0, zero4}, {32'd0, prev_z4});
            end
            hold4   = ov4 && !out_ready;
            prev_r4 = r4;
            prev_n4 = neg4;
            prev_z4 = zero4;
            if (ov4 && out_ready) begin
                check("extra_out4", {32'd0, q4.size() != 0}, 33'd1);
                if (q4.size() != 0) begin
                    e = q4.pop_front();
                    check("r4", {28'd0, r4}, e.r);
                    check("neg4", {32'd0, neg4}, {32'd0, e.n});
                    check("zero4", {32'd0, zero4}, {32'd0, e.z});
                end
            end
            if (ov16 && out_ready) begin
                check("extra_out16", {32'd0, q16.size() != 0}, 33'd1);
                if (q16.size() != 0) begin
                    e = q16.pop_front();
                    check("r16", {16'd0, r16}, e.r);
                    check("neg16", {32'd0, neg16}, {32'd0, e.n});
                    check("zero16", {32'd0, zero16}, {32'd0, e.z});
                end
            end
            if (in_valid && rdy4)
                q4.push_back(model(4, op, {28'd0, a16[3:0]}, {28'd0, b16[3:0]}, acc4));
            if (in_valid && rdy16)
                q16.push_back(model(16, op, {16'd0, a16}, {16'd0, b16}, acc16));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [15:0] av, input logic [15:0] bv);
        in_valid = v;
        op       = o;
        a16      = av;
        b16      = bv;
    endtask

    vec_t vecs[8];

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        acc4      = 33'd0;
        acc16     = 33'd0;
        hold4     = 1'b0;
        prev_r4   = 5'd0;
        prev_n4   = 1'b0;
        prev_z4   = 1'b0;
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, OP_AND, 16'd0, 16'd0);

        vecs[0] = '{OP_ADD,    4'd9,  4'd8,  5'b10001, 1'b0, 1'b0};
        vecs[1] = '{OP_SUB,    4'd3,  4'd5,  5'b11110, 1'b1, 1'b0};
        vecs[2] = '{OP_SUB,    4'd5,  4'd5,  5'b00000, 1'b0, 1'b1};
        vecs[3] = '{OP_AND,    4'd12, 4'd10, 5'b01000, 1'b0, 1'b0};
        vecs[4] = '{OP_OR,     4'd5,  4'd2,  5'b00111, 1'b0, 1'b0};
        vecs[5] = '{OP_XOR,    4'd15, 4'd5,  5'b01010, 1'b0, 1'b0};
        vecs[6] = '{OP_PASS_A, 4'd6,  4'd9,  5'b00110, 1'b0, 1'b0};
        vecs[7] = '{OP_ADD,    4'd15, 4'd15, 5'b11110, 1'b0, 1'b0};

        // reset state, in_ready low during reset and high right after
        tick();
        tick();
        check("rst_out_valid", {32'd0, ov4}, 33'd0);
        check("rst_r", {28'd0, r4}, 33'd0);
        check("rst_neg", {32'd0, neg4}, 33'd0);
        check("rst_zero", {32'd0, zero4}, 33'd0);
        check("rst_in_ready", {32'd0, rdy4}, 33'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {32'd0, rdy4}, 33'd1);

        // table: one op at a time, result visible two cycles after acceptance
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vecs[i].op, {12'd0, vecs[i].a}, {12'd0, vecs[i].b});
            tick();
            drive(1'b0, OP_AND, 16'd0, 16'd0);
            tick();
            check("tbl_valid", {32'd0, ov4}, 33'd1);
            check("tbl_r", {28'd0, r4}, {28'd0, vecs[i].r});
            check("tbl_neg", {32'd0, neg4}, {32'd0, vecs[i].n});
            check("tbl_zero", {32'd0, zero4}, {32'd0, vecs[i].z});
            tick();
        end

        // backpressure: two accepted then in_ready drops, order kept on release
        out_ready = 1'b0;
        drive(1'b1, OP_ADD, 16'd1, 16'd1);
        #1;
        check("bp_rdy0", {32'd0, rdy4}, 33'd1);
        tick();
        drive(1'b1, OP_OR, 16'd4, 16'd2);
        #1;
        check("bp_rdy1", {32'd0, rdy4}, 33'd1);
        tick();
        drive(1'b1, OP_AND, 16'd6, 16'd3);
        #1;
        check("bp_rdy2", {32'd0, rdy4}, 33'd0);
        tick();
        check("bp_rdy3", {32'd0, rdy4}, 33'd0);
        check("bp_hold_r", {28'd0, r4}, 33'd2);
        tick();
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", {32'd0, rdy4}, 33'd1);
        check("bp_out0", {28'd0, r4}, 33'd2);
        tick();
        drive(1'b0, OP_AND, 16'd0, 16'd0);
        check("bp_out1", {28'd0, r4}, 33'd6);
        tick();
        check("bp_out2", {28'd0, r4}, 33'd2);
        tick();
        check("bp_empty", {32'd0, ov4}, 33'd0);

        // accumulator back-to-back with wrap, then clear
        drive(1'b1, OP_ACC_ADD, 16'd15, 16'd7);
        tick();
        drive(1'b1, OP_ACC_ADD, 16'd15, 16'd0);
        tick();
        check("acc0", {28'd0, r4}, 33'd15);
        drive(1'b1, OP_ACC_ADD, 16'd5, 16'd3);
        tick();
        check("acc1", {28'd0, r4}, 33'd30);
        drive(1'b1, OP_ACC_CLR, 16'd0, 16'd0);
        tick();
        check("acc2_wrap", {28'd0, r4}, 33'd3);
        drive(1'b0, OP_AND, 16'd0, 16'd0);
        tick();
        check("acc_clr", {28'd0, r4}, 33'd3);
        drive(1'b1, OP_ACC_ADD, 16'd1, 16'd0);
        tick();
        drive(1'b0, OP_AND, 16'd0, 16'd0);
        tick();
        check("acc_after_clr", {28'd0, r4}, 33'd1);
        drive(1'b1, OP_ACC_CLR, 16'd0, 16'd0);
        tick();
        drive(1'b0, OP_AND, 16'd0, 16'd0);
        tick();
        tick();

        // reset with two ops in flight plus a coincident request
        out_ready = 1'b0;
        drive(1'b1, OP_ADD, 16'd1, 16'd2);
        tick();
        drive(1'b1, OP_ADD, 16'd3, 16'd4);
        tick();
        rst = 1'b1;
        drive(1'b1, OP_ADD, 16'd7, 16'd7);
        #1;
        check("rst_cycle_rdy", {32'd0, rdy4}, 33'd0);
        tick();
        rst = 1'b0;
        drive(1'b0, OP_AND, 16'd0, 16'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("flush_valid", {32'd0, ov4}, 33'd0);
            tick();
        end
        drive(1'b1, OP_ADD, 16'd2, 16'd3);
        tick();
        drive(1'b0, OP_AND, 16'd0, 16'd0);
        tick();
        check("post_flush_valid", {32'd0, ov4}, 33'd1);
        check("post_flush_r", {28'd0, r4}, 33'd5);
        tick();

        // random traffic, both widths, with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            op        = 3'($urandom_range(0, 7));
            a16       = 16'($urandom);
            b16       = 16'($urandom);
            if ($urandom_range(0, 7) == 0) b16 = a16;
            if ($urandom_range(0, 7) == 0) a16 = 16'(a16 & 16'h000f);
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("drained4", 33'(q4.size()), 33'd0);
        check("drained16", 33'(q16.size()), 33'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_alu.md
PIPELINED_ALU -- requirements
Module: pipelined_alu

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 in_valid  input  1  operation request present on a/b/op.
REQ-005 in_ready  output  1  block accepts the request this cycle.
REQ-006 a  input  WIDTH  operand A, unsigned.
REQ-007 b  input  WIDTH  operand B, unsigned.
REQ-008 op  input  3  opcode, encoded per REQ-013.
REQ-009 out_valid  output  1  r/neg/zero hold a valid result.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 r  output  WIDTH+1  result.
REQ-012 neg, zero  output  1 each  result flags.

Function
REQ-013 Opcodes SHALL be: 000 AND, 001 ADD, 010 OR, 011 SUB, 100 XOR, 101 ACC_ADD, 110 ACC_CLR, 111 PASS_A.
REQ-014 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-015 Two register stages: S1 captures a/b/op on input transfer; S2 holds the computed result, flags, and out_valid.
REQ-016 Latency SHALL be exactly 2 cycles from input transfer to out_valid when not stalled; throughput one op per cycle.
REQ-017 S2 SHALL load from S1 when S1 is valid and (S2 empty or S2 transfers this cycle); S1 SHALL load when S1 is empty or S1 moves to S2 this cycle.
REQ-018 in_ready SHALL be 1 when S1 is empty or S1 advances this cycle; in_ready combinational from state and out_ready only, never from in_valid.
REQ-019 With out_ready held 0, S2 and then S1 SHALL fill, then in_ready SHALL drop; r/neg/zero SHALL hold stable while out_valid && !out_ready.
REQ-020 AND/OR/XOR/PASS_A: r = zero-extended bitwise result (PASS_A: r = a).
REQ-021 ADD: r = a + b, WIDTH+1 bits, carry in MSB.
REQ-022 SUB: r = (a - b) mod 2^(WIDTH+1); neg SHALL be 1 iff b > a unsigned.
REQ-023 neg SHALL be 0 for every opcode except SUB.
REQ-024 zero SHALL be 1 iff r == 0, for every opcode.
REQ-025 Internal accumulator acc, WIDTH+1 bits, updated only when the op moves S1->S2.
REQ-026 ACC_ADD: r = (acc + a) mod 2^(WIDTH+1); acc <= same value; b ignored.
REQ-027 ACC_CLR: r = acc before clear; acc <= 0.
REQ-028 Back-to-back ACC ops SHALL see the acc updated by the previous ACC op (no hazard gap).
REQ-029 Ops in flight SHALL never be dropped or duplicated; order preserved.

Reset
REQ-030 On rst: out_valid=0, S1 empty, acc=0, r=0, neg=0, zero=0 on the following cycle.
REQ-031 rst mid-operation SHALL discard all in-flight ops; none appear at the output afterward.
REQ-032 in_ready SHALL be 0 during the rst cycle; 1 in the first cycle after rst deasserts.
REQ-033 An input transfer coincident with rst SHALL be ignored.

Verification (WIDTH=4)
REQ-034 ADD a=9 b=8, out_ready=1 -> two cycles later r=10001, neg=0, zero=0.
REQ-035 SUB a=3 b=5 -> r=11110, neg=1; SUB a=5 b=5 -> r=00000, neg=0, zero=1.
REQ-036 Ops ADD 1+1, OR 4|2, AND 6&3 back-to-back with out_ready=0 for 4 cycles -> in_ready drops after 2 accepted; on release outputs 00010, 00110, 00010 in order, none lost.
REQ-037 ACC_ADD a=15, ACC_ADD a=15, ACC_ADD a=5, ACC_CLR consecutive -> r=01111, 11110, 00011 (wrap), 00011; acc=0 after.
REQ-038 Accept two ops, assert rst one cycle while both in flight -> out_valid=0 thereafter, no stale result; next ADD 2+3 yields r=00101 two cycles after acceptance.
REQ-039 Random op/a/b/ready traffic vs reference model at WIDTH=4 and WIDTH=16 -> all results, flags, order match.
